// File: rtl/mem_resource_arb.sv
// Shared word array: data bus on port A, arbitrated ext/inst pair on port B.
// Acks and read data come back through fixed-latency pipelines.

module mem_resource_arb_pipe #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);
  logic [LAT-1:0] vld;
  logic [W-1:0]   stage [LAT];

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      vld[0] <= load;
      if (load) stage[0] <= load_data;
      // Data only advances alongside a valid, so the last stage holds between acks.
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) stage[i] <= stage[i-1];
      end
    end
  end

  assign valid = vld[LAT-1];
  assign data  = stage[LAT-1];
endmodule

module mem_resource_arb #(
  parameter int DATAW       = 64,
  parameter int INSTW       = 32,
  parameter int ADDRW       = 16,
  parameter int RD_LAT      = 1,
  parameter int EXT_MAX_RUN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_mem_data_bus_req,
  input  logic [1:0]       io_mem_data_bus_cmd,
  input  logic [ADDRW-1:0] io_mem_data_bus_addr,
  input  logic [2:0]       io_mem_data_bus_size,
  input  logic [DATAW-1:0] io_mem_data_bus_wrdata,
  output logic             io_mem_data_bus_ack,
  output logic             io_mem_data_bus_err,
  output logic [DATAW-1:0] io_mem_data_bus_rddata,
  input  logic             io_mem_inst_bus_req,
  input  logic [ADDRW-1:0] io_mem_inst_bus_addr,
  output logic             io_mem_inst_bus_ack,
  output logic [INSTW-1:0] io_mem_inst_bus_rddata,
  input  logic             io_mem_ext_bus_req,
  input  logic             io_mem_ext_bus_we,
  input  logic [ADDRW-1:0] io_mem_ext_bus_addr,
  input  logic [INSTW-1:0] io_mem_ext_bus_data,
  output logic             io_mem_ext_bus_ack,
  output logic [INSTW-1:0] io_mem_ext_bus_rddata
);
  localparam int BW     = DATAW / 8;
  localparam int OFFW   = $clog2(BW);
  localparam int IDXW   = ADDRW - OFFW;
  localparam int NWORDS = 1 << IDXW;
  localparam int LANEB  = INSTW / 8;
  localparam int NLANES = DATAW / INSTW;
  localparam int RUNW   = $clog2(EXT_MAX_RUN + 1);
  localparam logic [OFFW-1:0] LANE_MASK = OFFW'(LANEB - 1);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  logic [DATAW-1:0] mem [NWORDS];

  cmd_e             a_cmd;
  logic             a_valid, a_err, a_we;
  logic [IDXW-1:0]  a_idx;
  logic [OFFW-1:0]  a_off, a_align_mask;
  logic [BW-1:0]    a_be;
  logic [DATAW-1:0] a_wdata, a_word_sh, a_rdata;
  logic [DATAW:0]   a_out;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_cmd   = cmd_e'(io_mem_data_bus_cmd);
    a_valid = io_mem_data_bus_req && (a_cmd == CMD_WRITE || a_cmd == CMD_READ);
    a_idx   = io_mem_data_bus_addr[ADDRW-1:OFFW];
    a_off   = io_mem_data_bus_addr[OFFW-1:0];
    a_align_mask = '0;
    for (int i = 0; i < OFFW; i++) a_align_mask[i] = (i < int'(io_mem_data_bus_size));
    a_err   = (int'(io_mem_data_bus_size) > OFFW) || (|(a_off & a_align_mask));
    a_we    = a_valid && !a_err && (a_cmd == CMD_WRITE);
    a_wdata   = io_mem_data_bus_wrdata << {a_off, 3'b000};
    a_word_sh = mem[a_idx] >> {a_off, 3'b000};
    a_rdata = '0;
    a_be    = '0;
    for (int b = 0; b < BW; b++) begin
      if (b < (1 << int'(io_mem_data_bus_size))) a_rdata[8*b +: 8] = a_word_sh[8*b +: 8];
      a_be[b] = (b >= int'(a_off)) && (b < int'(a_off) + (1 << int'(io_mem_data_bus_size)));
    end
    if (a_err || a_cmd != CMD_READ) a_rdata = '0;
  end

  logic [RUNW-1:0]  run_cnt;
  logic             b_grant_ext, b_grant_inst, b_we;
  logic [ADDRW-1:0] b_addr;
  logic [IDXW-1:0]  b_idx;
  logic [OFFW-1:0]  b_lane_off;
  logic [BW-1:0]    b_be;
  logic [DATAW-1:0] b_wdata;
  logic [INSTW-1:0] b_rdata;

  always_comb begin
    // Ext wins unless it has already taken EXT_MAX_RUN slots in a row from a waiting inst.
    b_grant_ext  = io_mem_ext_bus_req &&
                   !(io_mem_inst_bus_req && run_cnt == RUNW'(EXT_MAX_RUN));
    b_grant_inst = io_mem_inst_bus_req && !b_grant_ext;
    b_we         = b_grant_ext && io_mem_ext_bus_we;
    b_addr       = b_grant_ext ? io_mem_ext_bus_addr : io_mem_inst_bus_addr;
    b_idx        = b_addr[ADDRW-1:OFFW];
    b_lane_off   = b_addr[OFFW-1:0] & ~LANE_MASK;
    b_be         = '0;
    for (int b = 0; b < BW; b++)
      b_be[b] = (b >= int'(b_lane_off)) && (b < int'(b_lane_off) + LANEB);
    b_wdata = {NLANES{io_mem_ext_bus_data}};
    b_rdata = INSTW'(mem[b_idx] >> {b_lane_off, 3'b000});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (!io_mem_inst_bus_req || b_grant_inst) begin
      run_cnt <= '0;
    end else if (b_grant_ext) begin
      run_cnt <= run_cnt + RUNW'(1);
    end
  end

  // NOTE: the array is deliberately left out of reset; only the control and output pipelines clear.
  // Port A's assignments come last so they win bytes both ports write in the same cycle.
  always_ff @(posedge clock) begin
    for (int b = 0; b < BW; b++)
      if (b_we && b_be[b]) mem[b_idx][8*b +: 8] <= b_wdata[8*b +: 8];
    for (int b = 0; b < BW; b++)
      if (a_we && a_be[b]) mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
  end

  mem_resource_arb_pipe #(.W(DATAW + 1), .LAT(RD_LAT)) u_pipe_data (
    .clock     (clock),
    .reset     (reset),
    .load      (a_valid),
    .load_data ({a_err, a_rdata}),
    .valid     (io_mem_data_bus_ack),
    .data      (a_out)
  );

  assign io_mem_data_bus_rddata = a_out[DATAW-1:0];
  assign io_mem_data_bus_err    = io_mem_data_bus_ack && a_out[DATAW];

  mem_resource_arb_pipe #(.W(INSTW), .LAT(RD_LAT)) u_pipe_inst (
    .clock     (clock),
    .reset     (reset),
    .load      (b_grant_inst),
    .load_data (b_rdata),
    .valid     (io_mem_inst_bus_ack),
    .data      (io_mem_inst_bus_rddata)
  );

  mem_resource_arb_pipe #(.W(INSTW), .LAT(RD_LAT)) u_pipe_ext (
    .clock     (clock),
    .reset     (reset),
    .load      (b_grant_ext),
    .load_data (b_we ? '0 : b_rdata),
    .valid     (io_mem_ext_bus_ack),
    .data      (io_mem_ext_bus_rddata)
  );
endmodule
